// File: rtl/wr_bank_buf_pkg.sv
// Shared definitions for the L1 write-side store buffer and the bank decode
// used by both the write and read paths.
//   - Geometry localparams: address/data/byte-enable widths, bank count and
//     the lowest address bit of the bank index field.
//   - wr_entry_t: one queued CPU word write {addr, data, be}.
package wr_bank_buf_pkg;

  localparam int WB_AW       = 32;
  localparam int WB_DW       = 32;
  localparam int WB_BEW      = WB_DW / 8;
  localparam int WB_NBANK    = 4;
  localparam int WB_BANK_LSB = 2;
  // Width of the bank index field carved out of the byte address.
  localparam int WB_BIW      = $clog2(WB_NBANK);

  typedef struct packed {
    logic [WB_AW-1:0]  addr;
    logic [WB_DW-1:0]  data;
    logic [WB_BEW-1:0] be;
  } wr_entry_t;

endpackage : wr_bank_buf_pkg

// File: rtl/wr_bank_buf_dec.sv
// Bank index to one-hot bank select, with an enable that forces all selects
// low. Shared between the write buffer and the read path.
// Ports:
//   idx : bank index
//   en  : decode enable; sel is all zeros when low
//   sel : one-hot bank select
module wr_bank_dec
  import wr_bank_buf_pkg::*;
#(
  parameter int NBANK = WB_NBANK,
  parameter int BIW   = $clog2(NBANK)
) (
  input  logic [BIW-1:0]   idx,
  input  logic             en,
  output logic [NBANK-1:0] sel
);

  // One-hot decode of the index, gated by the enable.
  always_comb begin
    sel = '0;
    if (en) begin
      sel[idx] = 1'b1;
    end else begin
      sel = '0;
    end
  end

endmodule : wr_bank_dec

// File: rtl/wr_bank_buf.sv
// Write-side store buffer sitting in front of the per-bank byte-enable gates
// of the L1 data array. CPU word writes are queued in order; a write to the
// same word as the youngest queued entry is folded into that entry, except
// when the youngest entry is also the head (so a stalled head never changes).
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   req_valid/req_ready             : CPU write handshake
//   req_addr, req_data, req_be      : byte address, data, byte enables
//   out_valid/out_ready             : head entry handshake to the bank array
//   out_addr, out_data, out_be      : head entry (out_be zero when idle)
//   out_bank_sel                    : one-hot bank of the head (zero when idle)
//   empty, full, count              : occupancy status
module wr_bank_buf
  import wr_bank_buf_pkg::*;
#(
  parameter int AW       = WB_AW,
  parameter int DW       = WB_DW,
  parameter int BEW      = DW / 8,
  parameter int DEPTH    = 4,
  parameter int NBANK    = WB_NBANK,
  parameter int BANK_LSB = WB_BANK_LSB
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [AW-1:0]              req_addr,
  input  logic [DW-1:0]              req_data,
  input  logic [BEW-1:0]             req_be,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [AW-1:0]              out_addr,
  output logic [DW-1:0]              out_data,
  output logic [BEW-1:0]             out_be,
  output logic [NBANK-1:0]           out_bank_sel,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int PW  = $clog2(DEPTH);
  localparam int OFF = $clog2(BEW);
  localparam int BIW = $clog2(NBANK);

  // Entry storage carries no reset; occupancy is tracked by count_r alone.
  logic [AW-1:0]  addr_mem_r [DEPTH];
  logic [DW-1:0]  data_mem_r [DEPTH];
  logic [BEW-1:0] be_mem_r   [DEPTH];

  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [CW-1:0] count_r;

  logic [PW-1:0] young_s;
  logic          be_nz_s;
  logic          full_s;
  logic          merge_hit_s;
  logic          push_s;
  logic          merge_s;
  logic          pop_s;
  logic          valid_s;

  // Handshake qualification: merge detection, push, merge and pop strobes.
  always_comb begin
    young_s     = tail_r - PW'(1);
    be_nz_s     = (req_be != '0);
    full_s      = (count_r == CW'(DEPTH));
    valid_s     = (count_r != '0);
    // count>=2 guarantees the youngest entry is not the head entry.
    merge_hit_s = req_valid && be_nz_s && (count_r >= CW'(2)) &&
                  (req_addr[AW-1:OFF] == addr_mem_r[young_s][AW-1:OFF]);
    push_s      = req_valid && (!full_s || merge_hit_s) && be_nz_s && !merge_hit_s;
    merge_s     = req_valid && merge_hit_s;
    pop_s       = valid_s && out_ready;
  end

  // Entry storage: write a new entry at tail, or merge bytes into the youngest.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      addr_mem_r[tail_r] <= req_addr;
      data_mem_r[tail_r] <= req_data;
      be_mem_r[tail_r]   <= req_be;
    end else if (!rst && merge_s) begin
      for (int i = 0; i < BEW; i++) begin
        if (req_be[i]) begin
          data_mem_r[young_s][8*i +: 8] <= req_data[8*i +: 8];
        end
      end
      be_mem_r[young_s] <= be_mem_r[young_s] | req_be;
    end
  end

  // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (push_s) begin
        tail_r <= tail_r + PW'(1);
      end
      if (pop_s) begin
        head_r <= head_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head presentation and status.
  always_comb begin
    req_ready = !full_s || merge_hit_s;
    out_valid = valid_s;
    out_addr  = addr_mem_r[head_r];
    out_data  = data_mem_r[head_r];
    if (valid_s) begin
      out_be = be_mem_r[head_r];
    end else begin
      out_be = '0;
    end
    empty = !valid_s;
    full  = full_s;
    count = count_r;
  end

  wr_bank_dec #(
    .NBANK (NBANK),
    .BIW   (BIW)
  ) u_bank_dec (
    .idx (out_addr[BANK_LSB +: BIW]),
    .en  (valid_s),
    .sel (out_bank_sel)
  );

endmodule : wr_bank_buf

// File: doc/wr_bank_buf.md
Name: wr_bank_buf

Overview:
Write-side store buffer for the L1 data array, directly upstream of the per-bank byte-enable gates.
- Accepts CPU word writes (address, data, byte enables) over a valid/ready handshake and holds them in a small in-order FIFO.
- Coalesces a write to the same word as the youngest queued entry.
- Presents the head entry with a one-hot bank select and byte enables; these feed the per-bank byte-enable gating stage.

Parameters:
AW, 32, address width (byte address)
DW, 32, data width
BEW, DW/8, byte-enable width
DEPTH, 4, buffer entries (power of 2, >=2)
NBANK, 4, number of data-array banks (power of 2)
BANK_LSB, 2, lowest address bit of the bank index field

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
req_valid  input  1  CPU write request valid
req_ready  output  1  buffer can accept or merge the request
req_addr  input  AW  byte address of the write
req_data  input  DW  write data
req_be  input  BEW  byte enables
out_valid  output  1  head entry valid
out_ready  input  1  bank array accepts the head entry
out_addr  output  AW  head address
out_data  output  DW  head data
out_be  output  BEW  head byte enables
out_bank_sel  output  NBANK  one-hot bank select of head
empty  output  1  count==0
full  output  1  count==DEPTH
count  output  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset and clocking
  - Single clock clk; rst is synchronous and active-high.
  - Reset sets head=tail=count=0, out_valid=0, empty=1, full=0, out_be=0, out_bank_sel=0.
  - Entry storage is not reset.
  - Reset mid-operation discards all queued writes; any request presented in the reset cycle is not accepted.
- Ordering
  - Strict FIFO order; no bypass.
  - A write accepted at edge N into an empty buffer appears at out_valid in the cycle after edge N (latency 1).
- Push
  - Occurs when req_valid && req_ready && req_be!=0 && !merge_hit.
  - Writes {addr, data, be} at tail; tail wraps modulo DEPTH.
- Zero byte enables
  - req_be==0 is handshaken (req_ready follows normal rules) and dropped: no entry, no state change.
- Merge
  - merge_hit = req_valid && req_be!=0 && count>=2 && req_addr[AW-1:$clog2(BEW)] == youngest entry word address.
  - On merge, bytes with req_be[i]=1 overwrite entry data byte i; entry be |= req_be; count unchanged.
  - Never merges into the head entry, which keeps outputs stable while stalled.
- Ready
  - req_ready = !full || merge_hit.
  - When full there is no same-cycle pass-through, even if out_ready=1.
- Pop
  - Occurs when out_valid && out_ready.
  - head advances and wraps modulo DEPTH.
- Simultaneous push and pop
  - count unchanged.
  - With count==1, the new entry becomes head on the next cycle.
- Output stability
  - While out_valid && !out_ready, out_addr, out_data, out_be and out_bank_sel hold constant.
- Output values
  - out_addr, out_data and out_be are read combinationally from the head entry; out_be is forced to 0 when !out_valid.
  - out_bank_sel is the one-hot decode of head addr[BANK_LSB +: $clog2(NBANK)] when out_valid, else 0.
- Status
  - out_valid = (count!=0); empty and full derive from count.
  - count never exceeds DEPTH and never underflows.

Decomposition:
- Shared cache package holds:
  - localparams for AW, DW, BEW, NBANK, BANK_LSB;
  - a packed wr_entry_t {addr, data, be};
  - a bank-index width constant.
- One natural sub-module: wr_bank_dec (index to one-hot bank decode with enable), reused by the read path.
- FIFO storage and merge logic stay in the top module.

Test Plan:
- Single write, no stall: req addr=0x0000_0014, data=0xA5A5_A5A5, be=0xF, out_ready=1 → one cycle later out_valid=1, out_bank_sel=0b0010, out_be=0xF; after pop, empty=1.
- Fill and back-pressure: out_ready=0, push 5 writes to distinct words → req_ready=0 after 4, full=1, count=4; raise out_ready → 4 entries drain in order, one per cycle.
- Merge: out_ready=0; push 0x100/be=0x1/data=0x11, then 0x200/be=0x3/data=0x2222, then 0x202/be=0xC/data=0x3333_0000 → count=2; second entry be=0xF, data=0x3333_2222; head unchanged.
- Head not merged: out_ready=0; push 0x40/be=0x1, then 0x40/be=0x2 → count=2, two separate entries; head out_be stays 0x1.
- Zero be: req_be=0 with req_valid=1 → req_ready=1, count unchanged, out_valid stays 0.
- Reset mid-stream: 3 entries queued, assert rst one cycle → next cycle count=0, out_valid=0, out_bank_sel=0, empty=1; subsequent push behaves as from reset.
